// File: rtl/playbus_responder.sv
// -----------------------------------------------------------------------------
// playbus_responder
//
// Target-side responder for the PlayBus. Decodes the initiator strobes and
// serves four resources over a 4-bit data bus:
//   - fixed ROM      (n_ROMO,  read)   ROM[a] = 15 - a
//   - 16x4 RAM       (n_RAMO,  read / n_RAMW, write)
//   - switch buffer  (n_SWBEN, read)   two-flop synchronised copy of SW
//   - LED latch      (LEDLTCH, write)
// It enforces one strobe at a time with an idle edge between transactions,
// flags violations on a sticky BUSERR, and counts completed transactions.
//
// Ports
//   CK2HZ    in   1  system clock, rising edge
//   CLR      in   1  synchronous reset, active-high
//   ADD      in   4  bus address
//   DIN      in   4  initiator write / latch data
//   n_ROMO   in   1  ROM output enable, active-low
//   n_RAMO   in   1  RAM output enable, active-low
//   n_RAMW   in   1  RAM write strobe, active-low
//   n_SWBEN  in   1  switch buffer enable, active-low
//   LEDLTCH  in   1  LED latch strobe, active-high
//   SW       in   4  raw switch inputs, asynchronous
//   DOUT     out  4  registered read data
//   DOE      out  1  DOUT valid / bus drive enable
//   LED      out  4  LED latch contents
//   BUSERR   out  1  sticky protocol-error flag
//   XCNT     out  8  completed-transaction count (wraps)
// -----------------------------------------------------------------------------
module playbus_responder (
    input  logic       CK2HZ,
    input  logic       CLR,
    input  logic [3:0] ADD,
    input  logic [3:0] DIN,
    input  logic       n_ROMO,
    input  logic       n_RAMO,
    input  logic       n_RAMW,
    input  logic       n_SWBEN,
    input  logic       LEDLTCH,
    input  logic [3:0] SW,
    output logic [3:0] DOUT,
    output logic       DOE,
    output logic [3:0] LED,
    output logic       BUSERR,
    output logic [7:0] XCNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ROM,
        S_RD_RAM,
        S_RD_SW,
        S_WR_RAM,
        S_LATCH,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        SRC_ROM,
        SRC_RAM,
        SRC_SW
    } rd_src_t;

    // -------------------------------------------------------------------------
    // Strobe decode
    // -------------------------------------------------------------------------
    // One bit per strobe, normalised to active-high.
    logic [4:0] act;
    logic [2:0] nact;
    state_t     strobe_state;   // state requested by a single active strobe

    assign act = {~n_ROMO, ~n_RAMO, ~n_SWBEN, ~n_RAMW, LEDLTCH};

    always_comb begin
        nact = 3'd0;
        for (int i = 0; i < 5; i++) begin
            nact = nact + 3'(act[i]);
        end
    end

    // Only meaningful when nact == 1; otherwise the FSM ignores it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        strobe_state = S_IDLE;
        if (act[4])      strobe_state = S_RD_ROM;
        else if (act[3]) strobe_state = S_RD_RAM;
        else if (act[2]) strobe_state = S_RD_SW;
        else if (act[1]) strobe_state = S_WR_RAM;
        else if (act[0]) strobe_state = S_LATCH;
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    state_t     state;
    state_t     next_state;
    logic [3:0] ram [16];
    logic [3:0] sw_meta;
    logic [3:0] sw_sync;

    // -------------------------------------------------------------------------
    // Next-state and action decode
    // -------------------------------------------------------------------------
    logic    dout_load;   // capture read data into DOUT this edge
    logic    ram_we;      // single RAM write this edge
    logic    led_we;      // single LED capture this edge
    logic    xcnt_inc;    // a transaction completes this edge
    logic    err_set;     // protocol violation detected this edge
    logic    doe_next;
    rd_src_t rd_src;

    always_comb begin
        next_state = state;
        dout_load  = 1'b0;
        ram_we     = 1'b0;
        led_we     = 1'b0;
        xcnt_inc   = 1'b0;
        err_set    = 1'b0;

        if (nact >= 3'd2) begin
            // Overlapping strobes are an error from any state; no side effects.
            next_state = S_ERR;
            err_set    = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (nact == 3'd1) begin
                        next_state = strobe_state;
                        // Entry actions happen on the assertion edge itself.
                        ram_we    = (strobe_state == S_WR_RAM);
                        led_we    = (strobe_state == S_LATCH);
                        dout_load = (strobe_state == S_RD_ROM) ||
                                    (strobe_state == S_RD_RAM) ||
                                    (strobe_state == S_RD_SW);
                    end
                end

                S_ERR: begin
                    // Leaving ERR is not a completed transaction.
                    if (nact == 3'd0) next_state = S_IDLE;
                end

                default: begin
                    // Active transaction states.
                    if (nact == 3'd0) begin
                        next_state = S_IDLE;
                        xcnt_inc   = 1'b1;
                    end else if (strobe_state != state) begin
                        // Strobe swapped without an idle edge in between.
                        next_state = S_ERR;
                        err_set    = 1'b1;
                    end else begin
                        // Reads track ADD every edge; writes stay single-shot.
                        dout_load = (state == S_RD_ROM) ||
                                    (state == S_RD_RAM) ||
                                    (state == S_RD_SW);
                    end
                end
            endcase
        end

        unique case (next_state)
            S_RD_RAM: rd_src = SRC_RAM;
            S_RD_SW:  rd_src = SRC_SW;
            default:  rd_src = SRC_ROM;
        endcase

        // The bus is driven exactly while a read transaction is in progress.
        doe_next = (next_state == S_RD_ROM) ||
                   (next_state == S_RD_RAM) ||
                   (next_state == S_RD_SW);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CK2HZ) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (CLR) state <= S_IDLE;
        else     state <= next_state;
    end

    // -------------------------------------------------------------------------
    // Switch synchroniser (SW is asynchronous to CK2HZ)
    // -------------------------------------------------------------------------
    always_ff @(posedge CK2HZ) begin
        if (CLR) begin
            sw_meta <= 4'd0;
            sw_sync <= 4'd0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    // -------------------------------------------------------------------------
    // RAM
    // -------------------------------------------------------------------------
    // NOTE: this RAM must read back as zero after CLR, so it is built from
    // resettable flops rather than an inferred memory macro, which cannot
    // be cleared in one cycle.
    always_ff @(posedge CK2HZ) begin
        if (CLR) begin
            for (int i = 0; i < 16; i++) begin
                ram[i] <= 4'd0;
            end
        end else if (ram_we) begin
            ram[ADD] <= DIN;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic [3:0] rd_data;

    always_comb begin
        unique case (rd_src)
            SRC_RAM: rd_data = ram[ADD];
            SRC_SW:  rd_data = sw_sync;       // switch read ignores ADD
            default: rd_data = 4'd15 - ADD;   // ROM image is 15 - address
        endcase
    end

    always_ff @(posedge CK2HZ) begin
        if (CLR) begin
            DOUT   <= 4'd0;
            DOE    <= 1'b0;
            LED    <= 4'd0;
            BUSERR <= 1'b0;
            XCNT   <= 8'd0;
        end else begin
            DOE <= doe_next;
            if (dout_load) DOUT   <= rd_data;
            if (led_we)    LED    <= DIN;
            if (err_set)   BUSERR <= 1'b1;
            if (xcnt_inc)  XCNT   <= XCNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_playbus_responder.sv
// -----------------------------------------------------------------------------
// tb_playbus_responder
//
// Directed bench for playbus_responder. Stimulus pushes the expected DOUT of
// every read beat into a queue; an independent monitor pops one entry for
// each edge on which the DUT asserts DOE. Status outputs (DOE low, LED,
// BUSERR, XCNT) are checked directly from the stimulus thread. Inputs change
// and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_playbus_responder;

    logic       CK2HZ = 1'b0;
    logic       CLR;
    logic [3:0] ADD;
    logic [3:0] DIN;
    logic       n_ROMO;
    logic       n_RAMO;
    logic       n_RAMW;
    logic       n_SWBEN;
    logic       LEDLTCH;
    logic [3:0] SW;
    logic [3:0] DOUT;
    logic       DOE;
    logic [3:0] LED;
    logic       BUSERR;
    logic [7:0] XCNT;

    int         tests = 0;
    int         fails = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    playbus_responder dut (
        .CK2HZ   (CK2HZ),
        .CLR     (CLR),
        .ADD     (ADD),
        .DIN     (DIN),
        .n_ROMO  (n_ROMO),
        .n_RAMO  (n_RAMO),
        .n_RAMW  (n_RAMW),
        .n_SWBEN (n_SWBEN),
        .LEDLTCH (LEDLTCH),
        .SW      (SW),
        .DOUT    (DOUT),
        .DOE     (DOE),
        .LED     (LED),
        .BUSERR  (BUSERR),
        .XCNT    (XCNT)
    );

    always #5 CK2HZ = ~CK2HZ;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Read-data monitor: one queue entry per edge that presents DOE.
    always @(negedge CK2HZ) begin
        if (DOE === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_doe: DOE=1 DOUT=%0h with no read pending (t=%0t)",
                         DOUT, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_dout", {28'd0, DOUT}, {28'd0, mon_exp});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CK2HZ);
    endtask

    task automatic bus_idle();
        n_ROMO  = 1'b1;
        n_RAMO  = 1'b1;
        n_RAMW  = 1'b1;
        n_SWBEN = 1'b1;
        LEDLTCH = 1'b0;
    endtask

    initial begin
        CLR = 1'b1;
        ADD = 4'd0;
        DIN = 4'd0;
        SW  = 4'd0;
        bus_idle();
        tick();
        tick();
        check("reset_doe",    DOE,    0);
        check("reset_dout",   DOUT,   0);
        check("reset_led",    LED,    0);
        check("reset_buserr", BUSERR, 0);
        check("reset_xcnt",   XCNT,   0);
        CLR = 1'b0;
        tick();

        // ---- ROM read, address change mid-read, release ----
        n_ROMO = 1'b0; ADD = 4'd3;
        exp_q.push_back(4'hC); tick();
        exp_q.push_back(4'hC); tick();
        ADD = 4'd9;
        exp_q.push_back(4'h6); tick();
        bus_idle(); tick();
        check("rom_release_doe", DOE,  0);
        check("rom_xcnt",        XCNT, 1);

        // ---- RAM write (single shot despite DIN changing), then read ----
        n_RAMW = 1'b0; ADD = 4'd5; DIN = 4'hA; tick();
        check("write_doe", DOE, 0);
        DIN = 4'h3; tick(); tick(); tick();
        bus_idle(); tick();
        check("write_xcnt", XCNT, 2);
        tick();
        n_RAMO = 1'b0; ADD = 4'd5;
        exp_q.push_back(4'hA); tick();
        ADD = 4'd4;
        exp_q.push_back(4'h0); tick();
        ADD = 4'd6;
        exp_q.push_back(4'h0); tick();
        bus_idle(); tick();
        check("ram_read_xcnt", XCNT, 3);

        // ---- LED latch: single capture ----
        LEDLTCH = 1'b1; DIN = 4'h6; tick();
        check("led_first", LED, 4'h6);
        DIN = 4'h9; tick(); tick();
        bus_idle(); tick();
        check("led_single", LED,  4'h6);
        check("led_xcnt",   XCNT, 4);

        // ---- Simultaneous strobes ----
        n_ROMO = 1'b0; n_SWBEN = 1'b0; ADD = 4'd1; tick();
        check("dual_buserr", BUSERR, 1);
        check("dual_doe",    DOE,    0);
        tick();
        bus_idle(); tick();
        check("dual_xcnt", XCNT, 4);
        n_ROMO = 1'b0; ADD = 4'd0;
        exp_q.push_back(4'hF); tick();
        bus_idle(); tick();
        check("after_err_xcnt",   XCNT,   5);
        check("after_err_buserr", BUSERR, 1);

        // ---- Strobe swap without an idle edge ----
        n_ROMO = 1'b0; ADD = 4'd1;
        exp_q.push_back(4'hE); tick();
        n_ROMO = 1'b1; n_RAMO = 1'b0; tick();
        check("swap_doe", DOE, 0);
        bus_idle(); tick();
        check("swap_xcnt", XCNT, 5);

        // ---- Second strobe joins an active read ----
        n_ROMO = 1'b0; ADD = 4'd2;
        exp_q.push_back(4'hD); tick();
        n_SWBEN = 1'b0; tick();
        check("join_doe", DOE, 0);
        bus_idle(); tick();
        check("join_xcnt",   XCNT,   5);
        check("join_buserr", BUSERR, 1);

        // ---- CLR beats a write strobe on the same edge ----
        CLR = 1'b1; n_RAMW = 1'b0; ADD = 4'd7; DIN = 4'h5; tick();
        check("clr_buserr", BUSERR, 0);
        check("clr_xcnt",   XCNT,   0);
        check("clr_led",    LED,    0);
        CLR = 1'b0; bus_idle(); tick();
        n_RAMO = 1'b0; ADD = 4'd7;
        exp_q.push_back(4'h0); tick();
        bus_idle(); tick();
        check("clr_nowrite_xcnt", XCNT, 1);

        // ---- Strobe held through CLR writes on the next edge ----
        CLR = 1'b1; n_RAMW = 1'b0; ADD = 4'd8; DIN = 4'hD; tick();
        CLR = 1'b0; tick();
        bus_idle(); tick();
        check("clr_held_xcnt", XCNT, 1);
        n_RAMO = 1'b0; ADD = 4'd8;
        exp_q.push_back(4'hD); tick();
        bus_idle(); tick();
        check("clr_held_read_xcnt", XCNT, 2);

        // ---- 256 ROM reads: counter wrap ----
        CLR = 1'b1; tick();
        CLR = 1'b0; SW = 4'd7;
        for (int i = 0; i < 256; i++) begin
            n_ROMO = 1'b0; ADD = 4'(i);
            exp_q.push_back(4'(15 - (i % 16))); tick();
            bus_idle(); tick();
            if (i == 254) check("xcnt_255", XCNT, 255);
        end
        check("xcnt_wrap", XCNT, 0);

        // ---- Switch read after settling ----
        n_SWBEN = 1'b0; ADD = 4'd3;
        exp_q.push_back(4'h7); tick();
        bus_idle(); tick();
        check("sw_xcnt", XCNT, 1);

        // ---- Switch change: two synchroniser edges plus the read edge ----
        SW = 4'd2; n_SWBEN = 1'b0;
        exp_q.push_back(4'h7); tick();
        exp_q.push_back(4'h7); tick();
        exp_q.push_back(4'h2); tick();
        bus_idle(); tick();
        check("sw_sync_xcnt", XCNT, 2);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
